// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiters.
// STREAM_RR_ARBITER_TAG_EN adds a source-index tag to the skid payload.
package stream_arb_pkg;

  localparam int DATA_WIDTH = 512;
  localparam int TAG_WIDTH  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Default-width payload; the arbiter top builds the same layout at its own DATA_WIDTH.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  keep;
    logic                  last;
`ifdef STREAM_RR_ARBITER_TAG_EN
    logic [TAG_WIDTH-1:0]  tag;
`endif
  } skid_payload_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping
// modulo N (N need not be a power of two).
module rr_pick #(
  parameter int N         = 4,
  parameter int IDX_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]         valid,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [IDX_WIDTH-1:0] sel,
  output logic                 any_valid
);

  function automatic int wrap_add(input int a, input int b);
    return (a + b >= N) ? a + b - N : a + b;
  endfunction

  logic [IDX_WIDTH-1:0] idx;

  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    sel = ptr;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDX_WIDTH'(wrap_add(int'(ptr), i));
      if (valid[idx]) sel = idx;
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin stream arbiter with a two-entry registered skid output.
// Optional: STREAM_RR_ARBITER_TAG_EN adds out_tag (source index aligned with out_data).
module stream_rr_arbiter #(
  parameter  int N_INPUTS   = 4,
  parameter  int DATA_WIDTH = 512,
  localparam int IDX_WIDTH  = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]            in_keep,
  input  logic [N_INPUTS-1:0]            in_last,
  input  logic [N_INPUTS-1:0]            in_valid,
  output logic [N_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_keep,
  output logic                           out_last,
  output logic                           out_valid,
`ifdef STREAM_RR_ARBITER_TAG_EN
  output logic [IDX_WIDTH-1:0]           out_tag,
`endif
  input  logic                           out_ready
);
  import stream_arb_pkg::*;

  // state  | meaning
  // IDLE   | no packet open; pick next source round-robin from rr_ptr
  // LOCKED | packet open on gnt; only gnt may transfer until its last beat

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  keep;
    logic                  last;
`ifdef STREAM_RR_ARBITER_TAG_EN
    logic [IDX_WIDTH-1:0]  tag;
`endif
  } entry_t;

  arb_state_t           state, state_nxt;
  logic [IDX_WIDTH-1:0] gnt, gnt_nxt, rr_ptr, ptr_nxt, sel, src;
  logic [N_INPUTS-1:0]  ready;
  logic                 any_valid, skid_ready, accept, pop;
  logic                 main_vld, over_vld;
  entry_t               main_q, over_q, in_beat, out_beat;

  rr_pick #(.N(N_INPUTS), .IDX_WIDTH(IDX_WIDTH)) u_pick (
    .valid    (in_valid),
    .ptr      (rr_ptr),
    .sel      (sel),
    .any_valid(any_valid)
  );

  // Registered full flag: no combinational path from out_ready to in_ready.
  assign skid_ready = ~over_vld;
  assign src        = (state == LOCKED) ? gnt : sel;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = rr_ptr;
    ready     = '0;
    if (state == LOCKED || any_valid) ready[src] = skid_ready;
    accept = in_valid[src] & ready[src];
    if (accept) begin
      if (in_last[src]) begin
        state_nxt = IDLE;
        ptr_nxt   = IDX_WIDTH'(rr_next(int'(src), N_INPUTS));
      end else begin
        state_nxt = LOCKED;
        gnt_nxt   = src;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= ptr_nxt;
    end
  end

  always_comb begin
    in_beat      = '0;
    in_beat.data = in_data[int'(src)*DATA_WIDTH +: DATA_WIDTH];
    in_beat.keep = in_keep[src];
    in_beat.last = in_last[src];
`ifdef STREAM_RR_ARBITER_TAG_EN
    in_beat.tag  = src;
`endif
  end

  assign pop = (main_vld | over_vld) & out_ready;

  // over holds the older beat whenever it is valid, and over valid implies main valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      over_vld <= 1'b0;
      main_q   <= '0;
      over_q   <= '0;
    end else if (over_vld) begin
      if (pop) over_vld <= 1'b0;
    end else if (main_vld) begin
      if (accept && !pop) begin
        over_q   <= main_q;
        over_vld <= 1'b1;
        main_q   <= in_beat;
      end else if (accept && pop) begin
        main_q   <= in_beat;
      end else if (pop) begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      main_q   <= in_beat;
      main_vld <= 1'b1;
    end
  end

  assign out_beat  = over_vld ? over_q : main_q;
  assign out_valid = rst_n & (main_vld | over_vld);
  assign in_ready  = rst_n ? ready : '0;
  assign out_data  = out_beat.data;
  assign out_keep  = out_beat.keep;
  assign out_last  = out_beat.last;
`ifdef STREAM_RR_ARBITER_TAG_EN
  assign out_tag   = out_beat.tag;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized scoreboard bench for stream_rr_arbiter: one N=4 and one N=3 instance
// driven side by side and checked against a packet-level round-robin model.
`timescale 1ns/1ps
module tb_stream_rr_arbiter;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic            rst_n;
  logic [4*DW-1:0] in_data  [2];
  logic [3:0]      in_keep  [2];
  logic [3:0]      in_last  [2];
  logic [3:0]      in_valid [2];
  logic            out_ready[2];

  logic [3:0]    ir4;
  logic [2:0]    ir3;
  logic [DW-1:0] od4, od3;
  logic          ok4, ok3, ol4, ol3, ov4, ov3;
`ifdef STREAM_RR_ARBITER_TAG_EN
  logic [1:0]    ot4, ot3;
`endif

  stream_rr_arbiter #(.N_INPUTS(4), .DATA_WIDTH(DW)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[0]), .in_keep(in_keep[0]), .in_last(in_last[0]),
    .in_valid(in_valid[0]), .in_ready(ir4),
    .out_data(od4), .out_keep(ok4), .out_last(ol4), .out_valid(ov4),
`ifdef STREAM_RR_ARBITER_TAG_EN
    .out_tag(ot4),
`endif
    .out_ready(out_ready[0])
  );

  stream_rr_arbiter #(.N_INPUTS(3), .DATA_WIDTH(DW)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[1][3*DW-1:0]), .in_keep(in_keep[1][2:0]), .in_last(in_last[1][2:0]),
    .in_valid(in_valid[1][2:0]), .in_ready(ir3),
    .out_data(od3), .out_keep(ok3), .out_last(ol3), .out_valid(ov3),
`ifdef STREAM_RR_ARBITER_TAG_EN
    .out_tag(ot3),
`endif
    .out_ready(out_ready[1])
  );

  typedef struct {
    int            cfg;
    int            src;
    logic [DW-1:0] data;
    logic          keep;
    logic          last;
  } beat_t;

  // Reference model: per config, the open packet's source (-1 = none), the
  // round-robin start pointer and the count of beats accepted but not yet emitted.
  beat_t         sb[$];
  int            lock[2];
  int            ptr[2];
  int            occ[2];
  logic          hold_v[2];
  logic [DW+1:0] hold_b[2];
  int            acc_cnt[2][4];

  int left[2][4];
  int seq[2][4];
  int seen[2][4];

  task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d t=%0t: got %0h expected %0h", name, c, $time, act, exp);
    end
  endtask

  task automatic mon(input int c);
    int            n, s, idx, acc;
    logic [3:0]    rdy, exp_rdy, vld;
    logic          ov, ordy, ok, ol;
    logic [DW-1:0] od;
    logic [1:0]    ot;
    beat_t         b;
    n    = (c == 0) ? 4 : 3;
    rdy  = (c == 0) ? ir4 : {1'b0, ir3};
    ov   = (c == 0) ? ov4 : ov3;
    od   = (c == 0) ? od4 : od3;
    ok   = (c == 0) ? ok4 : ok3;
    ol   = (c == 0) ? ol4 : ol3;
    ot   = 2'b00;
`ifdef STREAM_RR_ARBITER_TAG_EN
    ot   = (c == 0) ? ot4 : ot3;
`endif
    vld  = in_valid[c];
    ordy = out_ready[c];
    if (!rst_n) begin
      chk("reset_in_ready", c, 64'(rdy), 64'(0));
      chk("reset_out_valid", c, 64'(ov), 64'(0));
      for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].cfg == c) sb.delete(k);
      lock[c]   = -1;
      ptr[c]    = 0;
      occ[c]    = 0;
      hold_v[c] = 1'b0;
      return;
    end
    s = -1;
    if (lock[c] >= 0) s = lock[c];
    else begin
      for (int k = 0; k < n; k++) begin
        int j;
        j = (ptr[c] + k) % n;
        if (s < 0 && vld[j]) s = j;
      end
    end
    exp_rdy = 4'b0;
    if (s >= 0 && occ[c] < 2) exp_rdy[s] = 1'b1;
    chk("in_ready", c, 64'(rdy), 64'(exp_rdy));
    chk("out_valid", c, 64'(ov), 64'(occ[c] > 0));

    if (ov) begin
      if (hold_v[c]) chk("stall_hold", c, 64'({ol, ok, od}), 64'(hold_b[c]));
      if (ordy) begin
        idx = -1;
        for (int k = 0; k < sb.size(); k++) if (idx < 0 && sb[k].cfg == c) idx = k;
        if (idx < 0) begin
          chk("unexpected_beat", c, 64'(od), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          b = sb[idx];
          sb.delete(idx);
          if (occ[c] > 0) occ[c]--;
          chk("out_beat", c, 64'({ol, ok, od}), 64'({b.last, b.keep, b.data}));
`ifdef STREAM_RR_ARBITER_TAG_EN
          chk("out_tag", c, 64'(ot), 64'(b.src));
`endif
        end
        hold_v[c] = 1'b0;
      end else begin
        hold_v[c] = 1'b1;
        hold_b[c] = {ol, ok, od};
      end
    end else begin
      hold_v[c] = 1'b0;
    end

    acc = -1;
    for (int i = 0; i < n; i++) if (vld[i] && rdy[i] && acc < 0) acc = i;
    if (acc >= 0) begin
      b.cfg  = c;
      b.src  = acc;
      b.data = in_data[c][acc*DW +: DW];
      b.keep = in_keep[c][acc];
      b.last = in_last[c][acc];
      sb.push_back(b);
      occ[c]++;
      acc_cnt[c][acc]++;
      if (b.last) begin
        lock[c] = -1;
        ptr[c]  = (acc + 1) % n;
      end else begin
        lock[c] = acc;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  logic [4:0] rpat = 5'b11001;

  task automatic drive_phase(input logic [3:0] m0, input logic [3:0] m1, input int pval,
                             input int maxlen, input int rmode, input int cycles);
    for (int t = 0; t < cycles; t++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        int         n;
        logic [3:0] m;
        n = (c == 0) ? 4 : 3;
        m = (c == 0) ? m0 : m1;
        for (int i = 0; i < 4; i++) begin
          if (i >= n) begin
            in_valid[c][i] = 1'b0;
            in_last[c][i]  = 1'b0;
            in_keep[c][i]  = 1'b0;
            in_data[c][i*DW +: DW] = '0;
          end else begin
            if (acc_cnt[c][i] != seen[c][i]) begin
              seen[c][i] = acc_cnt[c][i];
              left[c][i]--;
              seq[c][i]++;
            end
            if (left[c][i] <= 0) left[c][i] = int'($urandom_range(maxlen, 1));
            in_data[c][i*DW +: DW] = {4'(i), 12'(seq[c][i])};
            in_last[c][i]  = (left[c][i] == 1);
            in_keep[c][i]  = 1'($urandom_range(1, 0));
            in_valid[c][i] = m[i] && ($urandom_range(99, 0) < pval);
          end
        end
        case (rmode)
          0:       out_ready[c] = 1'b1;
          1:       out_ready[c] = 1'($urandom_range(1, 0));
          default: out_ready[c] = rpat[t % 5];
        endcase
      end
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) left[c][i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_data[c]   = '0;
      in_keep[c]   = '0;
      in_last[c]   = '0;
      in_valid[c]  = '0;
      out_ready[c] = 1'b1;
      lock[c]      = -1;
      ptr[c]       = 0;
      occ[c]       = 0;
      hold_v[c]    = 1'b0;
      hold_b[c]    = '0;
      for (int i = 0; i < 4; i++) begin
        acc_cnt[c][i] = 0;
        left[c][i]    = 0;
        seq[c][i]     = 16 * i;
        seen[c][i]    = 0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive_phase(4'b0110, 4'b0111, 100, 1, 0, 40);   // singles; N=3 exercises 2->0 wrap
    drive_phase(4'b1111, 4'b0111, 100, 4, 0, 200);  // multi-beat packets, no back-pressure
    drive_phase(4'b1111, 4'b0111, 60, 5, 1, 300);   // bubbles inside packets, random stalls
    drive_phase(4'b1000, 4'b0100, 100, 8, 2, 100);  // one stream, out_ready 1,0,0,1,1
    drive_phase(4'b1111, 4'b0111, 100, 4, 0, 6);
    reset_pulse();                                  // lands mid-packet
    drive_phase(4'b1111, 4'b0111, 100, 1, 0, 20);
    drive_phase(4'b1111, 4'b0111, 80, 3, 1, 300);
    drive_phase(4'b0000, 4'b0000, 0, 1, 0, 10);     // drain

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
